// File: rtl/mem_rr_arbiter_if.sv
// Bundle of request, response and memory-side signals for mem_rr_arbiter.
// The slave modport is the arbiter's view; master is the client/memory side.
interface mem_rr_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DEPTH   = 16,
  parameter int WIDTH   = 8
);
  localparam int AW = $clog2(DEPTH);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       req_we;
  logic [NUM_REQ*AW-1:0]    req_addr;
  logic [NUM_REQ*WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]         rsp_rdata;
  logic                     mem_write_en;
  logic [AW-1:0]            mem_addr;
  logic [WIDTH-1:0]         mem_data_in;
  logic [WIDTH-1:0]         mem_data_out;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_data_out,
    output req_ready, rsp_valid, rsp_rdata, mem_write_en, mem_addr, mem_data_in
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_data_out,
    input  req_ready, rsp_valid, rsp_rdata, mem_write_en, mem_addr, mem_data_in
  );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Round-robin sequencer sharing one single-port memory among NUM_REQ clients.
// One request in flight: IDLE (accept) -> ACCESS (drive memory) -> RESP (pulse owner).
module mem_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DEPTH   = 16,
  parameter int WIDTH   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_rr_arbiter_if.slave     bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int GW = $clog2(NUM_REQ);
  localparam logic [GW:0] NUM_REQ_W = (GW+1)'(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [GW-1:0]      r_last_grant;
  logic [GW-1:0]      r_owner;
  logic               r_we;
  logic [AW-1:0]      r_addr;
  logic [WIDTH-1:0]   r_wdata;
  logic [WIDTH-1:0]   r_rsp_rdata;

  logic [AW-1:0]      w_addr_arr  [NUM_REQ];
  logic [WIDTH-1:0]   w_wdata_arr [NUM_REQ];
  logic [GW:0]        w_sum       [NUM_REQ];
  logic [GW-1:0]      w_cand      [NUM_REQ];
  logic               w_found;
  logic [GW-1:0]      w_winner;
  logic               w_xfer;

  // w_cand[k] is the requester index at rotation offset k+1 past the last grant.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign w_addr_arr[gi]  = bus.req_addr[gi*AW +: AW];
      assign w_wdata_arr[gi] = bus.req_wdata[gi*WIDTH +: WIDTH];
      assign w_sum[gi]       = {1'b0, r_last_grant} + (GW+1)'(gi + 1);
      assign w_cand[gi]      = (w_sum[gi] >= NUM_REQ_W) ? GW'(w_sum[gi] - NUM_REQ_W)
                                                        : GW'(w_sum[gi]);
    end
  endgenerate

  // Scan from the farthest offset down so the nearest valid requester wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[w_cand[k]]) begin
        w_found  = 1'b1;
        w_winner = w_cand[k];
      end
    end
  end

  assign w_xfer = (r_state == S_IDLE) && w_found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_xfer) w_state_next = S_ACCESS;
      S_ACCESS: w_state_next = S_RESP;
      S_RESP:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Ready is gated by rst_n so no grant is advertised while reset is held.
  always_comb begin
    bus.req_ready    = '0;
    bus.rsp_valid    = '0;
    bus.mem_write_en = 1'b0;
    case (r_state)
      S_IDLE:   if (rst_n && w_found) bus.req_ready[w_winner] = 1'b1;
      S_ACCESS: bus.mem_write_en = r_we;
      S_RESP:   bus.rsp_valid[r_owner] = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= GW'(NUM_REQ - 1);
      r_owner      <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rsp_rdata  <= '0;
    end else begin
      if (w_xfer) begin
        r_last_grant <= w_winner;
        r_owner      <= w_winner;
        r_we         <= bus.req_we[w_winner];
        r_addr       <= w_addr_arr[w_winner];
        r_wdata      <= w_wdata_arr[w_winner];
      end
      if (r_state == S_ACCESS) begin
        r_rsp_rdata <= r_we ? '0 : bus.mem_data_out;
      end
    end
  end

  // Address and write data only change on acceptance, so they hold outside ACCESS.
  assign bus.mem_addr    = r_addr;
  assign bus.mem_data_in = r_wdata;
  assign bus.rsp_rdata   = r_rsp_rdata;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: directed scenarios plus random traffic against a
// transaction-timeline model (accept at T, memory at T+1, response at T+2).
`timescale 1ns/1ps
module tb_mem_rr_arbiter;
  localparam int NUM_REQ = 2;
  localparam int DEPTH   = 16;
  localparam int WIDTH   = 8;
  localparam int AW      = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  mem_rr_arbiter #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory instance: sync write, combinational read; contents survive reset.
  logic [WIDTH-1:0] mem [DEPTH];
  logic             mem_init = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (!mem_init) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= WIDTH'(i * 37 + 11);
        mem_init <= 1'b1;
      end
    end else if (bus.mem_write_en) begin
      mem[bus.mem_addr] <= bus.mem_data_in;
    end
  end
  assign bus.mem_data_out = mem[bus.mem_addr];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: "since" = cycles since the last acceptance edge (99 = none).
  int               since   = 99;
  int               lg      = NUM_REQ - 1;
  int               owner_m = 0;
  int               exp_win = -1;
  logic             we_m    = 1'b0;
  logic [AW-1:0]    addr_m  = '0;
  logic [WIDTH-1:0] wd_m    = '0;
  logic [WIDTH-1:0] rdata_m = '0;
  logic [WIDTH-1:0] ref_mem [DEPTH];
  logic             ref_init = 1'b0;

  function automatic int pick(input logic [NUM_REQ-1:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input int w);
    logic [NUM_REQ-1:0] r;
    r = '0;
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      since   <= 99;
      lg      <= NUM_REQ - 1;
      owner_m <= 0;
      we_m    <= 1'b0;
      addr_m  <= '0;
      wd_m    <= '0;
      rdata_m <= '0;
      if (!ref_init) begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] <= WIDTH'(i * 37 + 11);
        ref_init <= 1'b1;
      end
    end else begin
      if (since == 1) begin
        if (we_m) begin
          ref_mem[addr_m] <= wd_m;
          rdata_m         <= '0;
        end else begin
          rdata_m <= ref_mem[addr_m];
        end
      end
      if (exp_win >= 0) begin
        since   <= 1;
        lg      <= exp_win;
        owner_m <= exp_win;
        we_m    <= bus.req_we[exp_win];
        addr_m  <= bus.req_addr[exp_win*AW +: AW];
        wd_m    <= bus.req_wdata[exp_win*WIDTH +: WIDTH];
      end else if (since < 99) begin
        since <= since + 1;
      end
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_win <= (since >= 3) ? pick(bus.req_valid, lg) : -1;
      chk("req_ready", 32'(bus.req_ready), 32'(onehot((since >= 3) ? pick(bus.req_valid, lg) : -1)));
      chk("mem_write_en", 32'(bus.mem_write_en), 32'(since == 1 && we_m));
      chk("mem_addr", 32'(bus.mem_addr), 32'(addr_m));
      chk("mem_data_in", 32'(bus.mem_data_in), 32'(wd_m));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'((since == 2) ? onehot(owner_m) : '0));
      chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(rdata_m));
      if (since == 2)
        $display("txn owner=%0d we=%0d addr=%0d wdata=%02h rdata=%02h", owner_m, we_m, addr_m, wd_m, bus.rsp_rdata);
    end else begin
      exp_win <= -1;
    end
  end

  task automatic drive(input int i, input logic v, input logic we,
                       input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    bus.req_valid[i]                = v;
    bus.req_we[i]                   = we;
    bus.req_addr[i*AW +: AW]        = a;
    bus.req_wdata[i*WIDTH +: WIDTH] = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int grants[$];
    int gcyc[$];
    int waited;
    logic [NUM_REQ-1:0] acc;

    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'h0);
    chk("rst_write_en", 32'(bus.mem_write_en), 32'h0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("rst_mem_data_in", 32'(bus.mem_data_in), 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // 1) req0 write addr=3 data=A5
    drive(0, 1'b1, 1'b1, 4'd3, 8'hA5);
    @(negedge clk); chk("t1_ready", 32'(bus.req_ready), 32'h1);
    next_cycle(); drive(0, 1'b0, 1'b0, 4'd0, 8'h00);
    @(negedge clk);
    chk("t1_write_en", 32'(bus.mem_write_en), 32'h1);
    chk("t1_addr", 32'(bus.mem_addr), 32'h3);
    @(negedge clk);
    chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t1_rdata", 32'(bus.rsp_rdata), 32'h0);

    // 2) req1 read addr=3 returns the value just written
    next_cycle(); drive(1, 1'b1, 1'b0, 4'd3, 8'h00);
    @(negedge clk); chk("t2_ready", 32'(bus.req_ready), 32'h2);
    next_cycle(); drive(1, 1'b0, 1'b0, 4'd0, 8'h00);
    @(negedge clk); chk("t2_write_en", 32'(bus.mem_write_en), 32'h0);
    @(negedge clk);
    chk("t2_rsp_valid", 32'(bus.rsp_valid), 32'h2);
    chk("t2_rdata", 32'(bus.rsp_rdata), 32'hA5);

    // 3) both valid continuously: grants alternate, one every 3 cycles
    next_cycle();
    drive(0, 1'b1, 1'($urandom_range(0, 1)), AW'(8 + $urandom_range(0, 5)), WIDTH'($urandom));
    drive(1, 1'b1, 1'($urandom_range(0, 1)), AW'(8 + $urandom_range(0, 5)), WIDTH'($urandom));
    for (int c = 0; c < 40 && grants.size() < 6; c++) begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      if (acc != '0) begin
        grants.push_back(acc[1] ? 1 : 0);
        gcyc.push_back(c);
      end
      next_cycle();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i])
          drive(i, grants.size() < 6, 1'($urandom_range(0, 1)), AW'(8 + $urandom_range(0, 5)), WIDTH'($urandom));
      end
    end
    drive(0, 1'b0, 1'b0, 4'd0, 8'h00);
    drive(1, 1'b0, 1'b0, 4'd0, 8'h00);
    chk("t3_grant_count", 32'(grants.size()), 32'd6);
    for (int k = 0; k < grants.size(); k++) chk("t3_grant_order", 32'(grants[k]), 32'(k % 2));
    for (int k = 1; k < gcyc.size(); k++) chk("t3_accept_gap", 32'(gcyc[k] - gcyc[k-1]), 32'd3);

    // 4) req1 alone after a req1 grant is granted again
    for (int n = 0; n < 2; n++) begin
      drive(1, 1'b1, 1'b0, AW'(n), 8'h00);
      waited = 0;
      @(negedge clk);
      while (bus.req_ready == '0 && waited < 10) begin
        next_cycle();
        @(negedge clk);
        waited++;
      end
      chk("t4_grant_req1", 32'(bus.req_ready), 32'h2);
      next_cycle();
      drive(1, 1'b0, 1'b0, 4'd0, 8'h00);
    end

    // 6) req0 raised during ACCESS/RESP waits for IDLE
    drive(0, 1'b1, 1'b0, 4'd3, 8'h00);
    @(negedge clk); chk("t6_ready_access", 32'(bus.req_ready), 32'h0);
    next_cycle();
    @(negedge clk); chk("t6_ready_resp", 32'(bus.req_ready), 32'h0);
    next_cycle();
    @(negedge clk); chk("t6_ready_idle", 32'(bus.req_ready), 32'h1);
    next_cycle();
    drive(0, 1'b0, 1'b0, 4'd0, 8'h00);
    @(negedge clk);
    next_cycle();
    next_cycle();

    // 5) reset during ACCESS of a write aborts it
    drive(0, 1'b1, 1'b1, 4'd5, 8'h3C);
    @(negedge clk); chk("t5_ready", 32'(bus.req_ready), 32'h1);
    next_cycle();
    chk("t5_write_en_before", 32'(bus.mem_write_en), 32'h1);
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 4'd0, 8'h00);
    #1 chk("t5_write_en_after", 32'(bus.mem_write_en), 32'h0);
    repeat (2) begin
      @(negedge clk);
      chk("t5_no_rsp", 32'(bus.rsp_valid), 32'h0);
    end
    chk("t5_mem5_unchanged", 32'(mem[5]), 32'hC4);
    drive(0, 1'b1, 1'b0, 4'd5, 8'h00);
    drive(1, 1'b1, 1'b0, 4'd5, 8'h00);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk); chk("t5_first_after_reset", 32'(bus.req_ready), 32'h1);
    next_cycle();
    drive(0, 1'b0, 1'b0, 4'd0, 8'h00);
    drive(1, 1'b0, 1'b0, 4'd0, 8'h00);
    repeat (3) next_cycle();

    // Random traffic; requesters hold while pending and may withdraw.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      next_cycle();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!bus.req_valid[i] || acc[i]) begin
          drive(i, $urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)),
                AW'($urandom_range(0, DEPTH - 1)), WIDTH'($urandom));
        end else if ($urandom_range(0, 99) < 5) begin
          bus.req_valid[i] = 1'b0;
        end
      end
    end
    drive(0, 1'b0, 1'b0, 4'd0, 8'h00);
    drive(1, 1'b0, 1'b0, 4'd0, 8'h00);
    repeat (4) next_cycle();
    for (int i = 0; i < DEPTH; i++) chk("final_mem", 32'(mem[i]), 32'(ref_mem[i]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
